// File: rtl/demux6_stream_if.sv
// Stream bundle for demux6_stream: one valid/ready input with a 3-bit destination,
// six one-hot output channels on a shared data bus, and the discard status outputs.
interface demux6_stream_if;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned NUM_CH = 6;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 8;

    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [DATA_W-1:0] in_data;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  drop_cnt;
    logic              drop_pulse;

    // Producer/consumer side: drives input words and channel readies
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt, drop_pulse
    );

    // Demultiplexer side
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, drop_cnt, drop_pulse
    );
endinterface

// File: rtl/demux6_stream.sv
// Registered 1-to-6 stream demultiplexer, 4-bit data, destinations 6/7 discarded.
// Define DEMUX6_DROP_CNT_EN to compile in the saturating discard counter.
module demux6_stream (
    input  logic           clk,
    input  logic           areset_n,
    demux6_stream_if.slave bus
);
    localparam int unsigned DATA_W = 4;
    localparam int unsigned NUM_CH = 6;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 8;
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_CH - 1);

    // Holding register kept as a one-hot valid vector; "full" is its OR-reduction
    logic [NUM_CH-1:0] r_out_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_drop_pulse;

    logic [NUM_CH-1:0] w_out_valid_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_drain;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_load;
    logic              w_drop;

    // Ready only looks at held state and the addressed consumer's ready
    assign w_drain    = |(r_out_valid & bus.out_ready);
    assign w_in_ready = ~(|r_out_valid) | w_drain;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_load     = w_accept & (bus.in_sel <= MAX_SEL);
    assign w_drop     = w_accept & (bus.in_sel >  MAX_SEL);

    // Next holding-register contents: a new load wins over a drain
    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_data_nxt      = r_data;
        if (w_load) begin
            w_out_valid_nxt = NUM_CH'(1) << bus.in_sel;
            w_data_nxt      = bus.in_data;
        end else if (w_drain) begin
            w_out_valid_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_out_valid  <= '0;
            r_data       <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_data       <= w_data_nxt;
            r_drop_pulse <= w_drop;
        end
    end

`ifdef DEMUX6_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop_cnt;

    // Saturating count of discarded words, updated with the pulse
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.drop_cnt = CNT_W'(0);
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_data;
    assign bus.drop_pulse = r_drop_pulse;
endmodule

// File: tb/tb_demux6_stream.sv
// Self-checking bench for demux6_stream: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_demux6_stream;
    logic clk;
    logic areset_n;
    int   n_vec;
    int   n_err;

    demux6_stream_if bus ();

    demux6_stream dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       v;
        logic [2:0] s;
        logic [3:0] d;
        logic [5:0] r;
        logic       e_rdy;
        logic [5:0] e_ov;
        logic [3:0] e_od;
        logic       e_dp;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl [11];

    // Reference model state: what is held, for whom, and discard bookkeeping
    bit       m_full;
    int       m_ch;
    bit [3:0] m_data;
    int       m_cnt;
    bit       m_pulse;

    function automatic logic [7:0] cnt_exp(input int n);
`ifdef DEMUX6_DROP_CNT_EN
        return 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_ch    = 0;
        m_data  = 4'h0;
        m_cnt   = 0;
        m_pulse = 1'b0;
    endtask

    function automatic logic [5:0] model_ov();
        logic [5:0] v;
        v = 6'b0;
        if (m_full) v[m_ch] = 1'b1;
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"},  8'(bus.out_valid),  8'(model_ov()));
        chk({tag, ".out_data"},   8'(bus.out_data),   8'(m_data));
        chk({tag, ".drop_pulse"}, 8'(bus.drop_pulse), 8'(m_pulse));
        chk({tag, ".drop_cnt"},   bus.drop_cnt,       cnt_exp(m_cnt));
    endtask

    // One model-checked clock cycle; entered and left at a falling edge
    task automatic cycle(input logic v, input logic [2:0] s, input logic [3:0] d,
                         input logic [5:0] r, input string tag);
        bit rdy;
        bit acc;
        check_outputs(tag);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        rdy = !m_full || (r[m_ch] == 1'b1);
        #1;
        chk({tag, ".in_ready"}, 8'(bus.in_ready), 8'(rdy));
        @(posedge clk);
        acc = v && rdy;
        m_pulse = acc && (int'(s) >= 6);
        if (acc && int'(s) < 6) begin
            m_full = 1'b1;
            m_ch   = int'(s);
            m_data = d;
        end else if (m_full && r[m_ch]) begin
            m_full = 1'b0;
        end
        if (m_pulse && m_cnt < 255) m_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset_n      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 3'd0;
        bus.in_data   = 4'h0;
        bus.out_ready = 6'h00;
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        model_reset();
        #1;
        chk("rst.out_valid", 8'(bus.out_valid), 8'h00);
        chk("rst.out_data",  8'(bus.out_data),  8'h00);
        chk("rst.in_ready",  8'(bus.in_ready),  8'h01);
        chk("rst.drop_cnt",  bus.drop_cnt,      8'h00);
        chk("rst.drop_pulse", 8'(bus.drop_pulse), 8'h00);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        areset_n      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 3'd0;
        bus.in_data   = 4'h0;
        bus.out_ready = 6'h00;
        model_reset();

        // inputs this cycle | in_ready this cycle | outputs after the edge
        tbl[0]  = '{1'b1, 3'd3, 4'hA, 6'h3F, 1'b1, 6'b001000, 4'hA, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 3'd0, 4'h0, 6'h3F, 1'b1, 6'b000000, 4'hA, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 3'd5, 4'h7, 6'h00, 1'b1, 6'b100000, 4'h7, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 3'd2, 4'hF, 6'h1F, 1'b0, 6'b100000, 4'h7, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 3'd2, 4'hF, 6'h00, 1'b0, 6'b100000, 4'h7, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 3'd6, 4'h1, 6'h20, 1'b1, 6'b000000, 4'h7, 1'b1, 8'd1};
        tbl[6]  = '{1'b1, 3'd0, 4'h1, 6'h3F, 1'b1, 6'b000001, 4'h1, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 3'd1, 4'h2, 6'h3F, 1'b1, 6'b000010, 4'h2, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 3'd7, 4'h3, 6'h00, 1'b0, 6'b000010, 4'h2, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, 3'd7, 4'h3, 6'h02, 1'b1, 6'b000000, 4'h2, 1'b1, 8'd2};
        tbl[10] = '{1'b0, 3'd0, 4'h0, 6'h3F, 1'b1, 6'b000000, 4'h2, 1'b0, 8'd2};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            bus.in_valid  = tbl[i].v;
            bus.in_sel    = tbl[i].s;
            bus.in_data   = tbl[i].d;
            bus.out_ready = tbl[i].r;
            #1;
            chk($sformatf("tbl%0d.in_ready", i), 8'(bus.in_ready), 8'(tbl[i].e_rdy));
            @(negedge clk);
            chk($sformatf("tbl%0d.out_valid", i),  8'(bus.out_valid),  8'(tbl[i].e_ov));
            chk($sformatf("tbl%0d.out_data", i),   8'(bus.out_data),   8'(tbl[i].e_od));
            chk($sformatf("tbl%0d.drop_pulse", i), 8'(bus.drop_pulse), 8'(tbl[i].e_dp));
            chk($sformatf("tbl%0d.drop_cnt", i),   bus.drop_cnt,       cnt_exp(int'(tbl[i].e_cnt)));
        end

        // Back-pressure on channel 5 with other channels ready, then release
        do_reset();
        cycle(1'b1, 3'd5, 4'h7, 6'h00, "bp.load");
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd3, 4'hC, 6'h1F, "bp.hold");
        chk("bp.held_data", 8'(bus.out_data), 8'h07);
        cycle(1'b0, 3'd0, 4'h0, 6'h20, "bp.drain");
        cycle(1'b0, 3'd0, 4'h0, 6'h00, "bp.idle");

        // Back-to-back streaming to every channel
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'(i), 4'(i + 1), 6'h3F, "b2b");
        cycle(1'b0, 3'd0, 4'h0, 6'h3F, "b2b.end");
        cycle(1'b0, 3'd0, 4'h0, 6'h3F, "b2b.idle");

        // Invalid destinations until the counter saturates
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'(6 + (i % 2)), 4'(i), 6'h3F, "inv");
        cycle(1'b0, 3'd0, 4'h0, 6'h3F, "inv.end");
        chk("inv.saturated", bus.drop_cnt, cnt_exp(255));

        // Async reset between edges while a word is held and 12 drops are counted
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 3'd6, 4'h0, 6'h00, "ar.drop");
        cycle(1'b1, 3'd2, 4'h9, 6'h00, "ar.load");
        cycle(1'b0, 3'd0, 4'h0, 6'h00, "ar.hold");
        chk("ar.pre_cnt",   bus.drop_cnt,        cnt_exp(12));
        chk("ar.pre_valid", 8'(bus.out_valid),   8'h04);
        #2;
        areset_n = 1'b0;
        #1;
        chk("ar.out_valid", 8'(bus.out_valid), 8'h00);
        chk("ar.drop_cnt",  bus.drop_cnt,      8'h00);
        chk("ar.out_data",  8'(bus.out_data),  8'h00);
        chk("ar.in_ready",  8'(bus.in_ready),  8'h01);
        @(negedge clk);
        areset_n = 1'b1;
        model_reset();
        cycle(1'b0, 3'd0, 4'h0, 6'h3F, "ar.after");
        cycle(1'b0, 3'd0, 4'h0, 6'h3F, "ar.after2");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       rv;
            logic [2:0] rs;
            logic [3:0] rd;
            logic [5:0] rr;
            rv = ($urandom_range(0, 3) != 0);
            rs = 3'($urandom_range(0, 7));
            rd = 4'($urandom);
            rr = ($urandom_range(0, 2) == 0) ? 6'h3F : 6'($urandom);
            cycle(rv, rs, rd, rr, "rnd");
        end
        cycle(1'b0, 3'd0, 4'h0, 6'h3F, "rnd.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/demux6_stream.md
# demux6_stream

Registered 1-to-6 stream demultiplexer for 4-bit data: the distribution side of the 6-way select path. Accepts one word per cycle with a 3-bit destination on a valid/ready input. Delivers it one cycle later on one of six output channels that share a data bus and have one-hot valid and per-channel ready. Destinations 6 and 7 are invalid: such words are consumed and discarded, never forwarded.

## Interface
- No parameters; widths are fixed (data 4 bits, 6 channels, counter 8 bits).
- clk  input  1  rising-edge clock
- areset_n  input  1  one clock; reset asynchronous, active-low
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input word this cycle
- in_sel  input  3  destination channel, 0-5 valid, 6-7 invalid
- in_data  input  4  input word
- out_valid  output  6  one-hot; bit k means the word on out_data is for channel k
- out_ready  input  6  per-channel consumer ready
- out_data  output  4  shared output data bus
- drop_cnt  output  8  count of discarded invalid-destination words, saturating
- drop_pulse  output  1  one-cycle pulse when a word is discarded

## Operation
- Single output holding register: full flag, dest[2:0], data[3:0].
- out_valid[k] = full && (dest == k); out_data = held data, driven whether or not full.
- Output transfer on channel k happens when out_valid[k] && out_ready[k]. out_ready bits of non-addressed channels are ignored.
- in_ready = !full || drain, where drain = out_valid[dest] && out_ready[dest]. in_ready never depends on in_sel, in_valid or in_data.
- Input accept = in_valid && in_ready.
- Accept with in_sel <= 5: register loads {in_sel, in_data}, full = 1.
- Accept with in_sel >= 6: no load. drop_pulse = 1 next cycle. drop_cnt increments unless it is already 255.
- Drain without a valid-destination accept: full = 0, dest/data hold.
- Drain with a simultaneous valid-destination accept: register reloads, full stays 1. This gives back-to-back throughput of one word per cycle.
- Drain with a simultaneous invalid-destination accept: full = 0 and the drop is counted.
- While full and not draining, the held word and dest stay stable. in_data and in_sel changes are ignored until in_ready.

## Timing
- Reset (areset_n low, asynchronous): full = 0, dest = 0, data = 0, out_valid = 0, out_data = 0, drop_cnt = 0, drop_pulse = 0. The block is ready (in_ready = 1) immediately on deassertion.
- Reset asserted mid-transfer: the held word is lost and the count is cleared. No output is produced after release until the next accept.
- Latency: accept at edge N means out_valid is high after edge N, so the consumer can take the word at edge N+1.
- Throughput: 1 word/cycle when the addressed consumer holds out_ready high. With out_ready low, at most one word is buffered and in_ready stays low.
- in_ready, out_valid, out_data and drop_pulse are functions of registers and out_ready only. There is no combinational path from in_* to out_*.
- drop_cnt updates on the same edge that drop_pulse rises.

## Configuration
- DEMUX6_DROP_CNT_EN defined: drop_cnt register and saturating increment are compiled in, as described above.
- DEMUX6_DROP_CNT_EN undefined: drop_cnt is tied to 8'd0 and its register is removed. drop_pulse and discard behaviour are unchanged.

## Test plan
- Reset and idle: hold areset_n low, then release -> out_valid = 6'b000000, in_ready = 1, drop_cnt = 0.
- Single word: in_sel = 3, in_data = 4'hA, out_ready = 6'h3F -> next cycle out_valid = 6'b001000 and out_data = 4'hA for exactly one cycle.
- Back-pressure: send sel = 5, data = 4'h7 with out_ready[5] = 0 for 4 cycles -> out_valid[5] held, in_ready = 0, data stays 4'h7. Raise out_ready[5] -> drained, and in_ready = 1 in that same cycle.
- Back-to-back streaming: send sels 0,1,2,3,4,5 with data 1..6 on consecutive cycles, all ready -> six consecutive one-hot outputs with matching data and no bubbles. Ready on the wrong channel must not drain.
- Invalid destinations: send 300 words with in_sel = 6 or 7 -> no out_valid, drop_pulse once per word, drop_cnt saturates at 255. With DEMUX6_DROP_CNT_EN undefined -> drop_cnt = 0.
- Async reset mid-operation: assert areset_n low between edges while a word is held with drop_cnt = 12 -> out_valid = 0 and drop_cnt = 0 immediately, without waiting for a clock edge.
